// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble counting.
// Optional write-back bypass into the captured operands is enabled by defining WB_BYPASS_EN.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [31:0]      imm,
  input  logic [8:0]       ctrlIn,
  input  logic             inValid,
  input  logic             flush,
  input  logic             hold,
  input  logic             wbRegWrite,
  input  logic [4:0]       wbWriteReg,
  input  logic [31:0]      wbWriteData,
  output logic [31:0]      data1Out,
  output logic [31:0]      data2Out,
  output logic [31:0]      immOut,
  output logic [4:0]       rsOut,
  output logic [4:0]       rtOut,
  output logic [4:0]       rdOut,
  output logic [8:0]       ctrlOut,
  output logic             valid,
  output logic             stall,
  output logic [CNT_W-1:0] bubbleCnt
);

  localparam int MEM_READ = 6;

  logic [31:0]      data1_q, data1_d;
  logic [31:0]      data2_q, data2_d;
  logic [31:0]      imm_q, imm_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       rd_q, rd_d;
  logic [8:0]       ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall_w;
  logic [31:0]      op1, op2;

  // A bubble carries valid=0, so it can never trigger a stall.
  assign stall_w = valid_q & ctrl_q[MEM_READ] & (rt_q != 5'd0) &
                   ((rt_q == rs) | (rt_q == rt)) & inValid & ~hold & ~flush;

`ifdef WB_BYPASS_EN
  logic wb_hit1, wb_hit2;
  assign wb_hit1 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == rs);
  assign wb_hit2 = wbRegWrite & (wbWriteReg != 5'd0) & (wbWriteReg == rt);
  assign op1     = wb_hit1 ? wbWriteData : data1;
  assign op2     = wb_hit2 ? wbWriteData : data2;
`else
  logic unused_wb;
  assign unused_wb = ^{wbRegWrite, wbWriteReg, wbWriteData};
  assign op1       = data1;
  assign op2       = data2;
`endif

  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ctrl_d  = 9'd0;
      valid_d = 1'b0;
    end else if (!hold) begin
      if (stall_w) begin
        ctrl_d  = 9'd0;
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        data1_d = op1;
        data2_d = op2;
        imm_d   = imm;
        rs_d    = rs;
        rt_d    = rt;
        rd_d    = rd;
        ctrl_d  = inValid ? ctrlIn : 9'd0;
        valid_d = inValid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data1_q <= 32'd0;
      data2_q <= 32'd0;
      imm_q   <= 32'd0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      ctrl_q  <= 9'd0;
      valid_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data1Out  = data1_q;
  assign data2Out  = data2_q;
  assign immOut    = imm_q;
  assign rsOut     = rs_q;
  assign rtOut     = rt_q;
  assign rdOut     = rd_q;
  assign ctrlOut   = ctrl_q;
  assign valid     = valid_q;
  assign stall     = stall_w;
  assign bubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a second instance with CNT_W=4 shares the stimulus.
module tb_id_ex_stage;

  localparam logic [8:0] LW  = 9'b111010000;
  localparam logic [8:0] ADD = 9'b100001010;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP  = 32'hDEADBEEF;
  localparam logic [31:0] BYP2 = 32'h0000CAFE;
`else
  localparam logic [31:0] BYP  = 32'h0;
  localparam logic [31:0] BYP2 = 32'h00005678;
`endif

  logic        clk, rst;
  logic [31:0] data1, data2, imm, wbWriteData;
  logic [4:0]  rs, rt, rd, wbWriteReg;
  logic [8:0]  ctrlIn;
  logic        inValid, flush, hold, wbRegWrite;

  logic [31:0] data1Out, data2Out, immOut;
  logic [4:0]  rsOut, rtOut, rdOut;
  logic [8:0]  ctrlOut;
  logic        valid, stall;
  logic [15:0] bubbleCnt;

  logic [31:0] d1_4, d2_4, imm_4;
  logic [4:0]  rs_4, rt_4, rd_4;
  logic [8:0]  ctrl_4;
  logic        valid_4, stall_4;
  logic [3:0]  cnt_4;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  typedef struct {
    logic iv, fl, ho;
    logic [4:0] rs, rt, rd;
    logic [8:0] ctrl;
    logic [31:0] d1, d2, imm;
    logic wbw;
    logic [4:0] wbr;
    logic [31:0] wbd;
    logic e_stall, e_valid;
    logic [8:0] e_ctrl;
    logic [4:0] e_rs, e_rt, e_rd;
    logic [31:0] e_d1, e_d2, e_imm;
    int e_cnt;
  } vec_t;

  vec_t vecs[21];

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .ctrlIn(ctrlIn), .inValid(inValid), .flush(flush), .hold(hold),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
    .data1Out(data1Out), .data2Out(data2Out), .immOut(immOut), .rsOut(rsOut),
    .rtOut(rtOut), .rdOut(rdOut), .ctrlOut(ctrlOut), .valid(valid), .stall(stall),
    .bubbleCnt(bubbleCnt)
  );

  id_ex_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .ctrlIn(ctrlIn), .inValid(inValid), .flush(flush), .hold(hold),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
    .data1Out(d1_4), .data2Out(d2_4), .immOut(imm_4), .rsOut(rs_4),
    .rtOut(rt_4), .rdOut(rd_4), .ctrlOut(ctrl_4), .valid(valid_4), .stall(stall_4),
    .bubbleCnt(cnt_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    inValid = v.iv; flush = v.fl; hold = v.ho;
    rs = v.rs; rt = v.rt; rd = v.rd; ctrlIn = v.ctrl;
    data1 = v.d1; data2 = v.d2; imm = v.imm;
    wbRegWrite = v.wbw; wbWriteReg = v.wbr; wbWriteData = v.wbd;
    #1;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v.e_valid});
    chk({tag, ".ctrl"}, {23'd0, ctrlOut}, {23'd0, v.e_ctrl});
    chk({tag, ".cnt"}, {16'd0, bubbleCnt}, v.e_cnt);
    chk({tag, ".cnt4"}, {28'd0, cnt_4}, sat4(v.e_cnt));
    if (v.e_valid) begin
      chk({tag, ".rs"}, {27'd0, rsOut}, {27'd0, v.e_rs});
      chk({tag, ".rt"}, {27'd0, rtOut}, {27'd0, v.e_rt});
      chk({tag, ".rd"}, {27'd0, rdOut}, {27'd0, v.e_rd});
      chk({tag, ".d1"}, data1Out, v.e_d1);
      chk({tag, ".d2"}, data2Out, v.e_d2);
      chk({tag, ".imm"}, immOut, v.e_imm);
    end
  endtask

  initial begin
    vec_t sv;
    // load lw rt=8; dependent add stalls once, then is captured
    vecs[0]  = '{1,0,0, 1,8,0,  LW,  'h11,'h22,'h4,  0,0,0, 0,1,LW, 1,8,0,  'h11,'h22,'h4, 0};
    vecs[1]  = '{1,0,0, 8,9,10, ADD, 'h33,'h44,0,    0,0,0, 1,0,0,  0,0,0,  0,0,0,          1};
    vecs[2]  = '{1,0,0, 8,9,10, ADD, 'h33,'h44,0,    0,0,0, 0,1,ADD,8,9,10, 'h33,'h44,0,    1};
    // lw to r0 never stalls a consumer of r0
    vecs[3]  = '{1,0,0, 2,0,0,  LW,  'h55,'h66,8,    0,0,0, 0,1,LW, 2,0,0,  'h55,'h66,8,    1};
    vecs[4]  = '{1,0,0, 0,0,3,  ADD, 'h77,'h88,0,    0,0,0, 0,1,ADD,0,0,3,  'h77,'h88,0,    1};
    // back-to-back loads into r7
    vecs[5]  = '{1,0,0, 1,7,0,  LW,  1,2,'hC,        0,0,0, 0,1,LW, 1,7,0,  1,2,'hC,        1};
    vecs[6]  = '{1,0,0, 3,7,0,  LW,  3,4,'h10,       0,0,0, 1,0,0,  0,0,0,  0,0,0,          2};
    vecs[7]  = '{1,0,0, 3,7,0,  LW,  3,4,'h10,       0,0,0, 0,1,LW, 3,7,0,  3,4,'h10,       2};
    vecs[8]  = '{1,0,0, 7,1,4,  ADD, 5,6,0,          0,0,0, 1,0,0,  0,0,0,  0,0,0,          3};
    vecs[9]  = '{1,0,0, 7,1,4,  ADD, 5,6,0,          0,0,0, 0,1,ADD,7,1,4,  5,6,0,          3};
    // hold three cycles with a would-be hazard present
    vecs[10] = '{1,0,0, 0,5,0,  LW,  'hA,'hB,'h10,   0,0,0, 0,1,LW, 0,5,0,  'hA,'hB,'h10,   3};
    vecs[11] = '{1,0,1, 5,6,2,  ADD, 'hE,'hF,0,      0,0,0, 0,1,LW, 0,5,0,  'hA,'hB,'h10,   3};
    vecs[12] = '{1,0,1, 5,6,2,  ADD, 'hE,'hF,0,      0,0,0, 0,1,LW, 0,5,0,  'hA,'hB,'h10,   3};
    vecs[13] = '{1,0,1, 5,6,2,  ADD, 'hE,'hF,0,      0,0,0, 0,1,LW, 0,5,0,  'hA,'hB,'h10,   3};
    // flush wins over hold
    vecs[14] = '{1,1,1, 5,6,2,  ADD, 'hE,'hF,0,      0,0,0, 0,0,0,  0,0,0,  0,0,0,          3};
    // write-back bypass cases
    vecs[15] = '{1,0,0, 5,5,6,  ADD, 0,0,0,          1,5,'hDEADBEEF, 0,1,ADD,5,5,6, BYP,BYP,0, 3};
    vecs[16] = '{1,0,0, 0,0,6,  ADD, 1,2,3,          1,0,'hDEADBEEF, 0,1,ADD,0,0,6, 1,2,3,     3};
    vecs[17] = '{1,0,0, 5,6,1,  ADD, 'h1234,'h5678,0, 1,6,'hCAFE,    0,1,ADD,5,6,1, 'h1234,BYP2,0, 3};
    vecs[18] = '{1,0,0, 5,5,1,  ADD, 'h9,'h8,0,      0,5,'hCAFE,     0,1,ADD,5,5,1, 'h9,'h8,0, 3};
    // invalid ID becomes a bubble; a bubble never stalls
    vecs[19] = '{0,0,0, 1,2,3,  LW,  7,7,7,          0,0,0, 0,0,0,  0,0,0,  0,0,0,          3};
    vecs[20] = '{1,0,0, 2,2,4,  ADD, 'h21,'h22,'h23, 0,0,0, 0,1,ADD,2,2,4,  'h21,'h22,'h23, 3};

    rst = 1'b0;
    inValid = 0; flush = 0; hold = 0; rs = 0; rt = 0; rd = 0; ctrlIn = 0;
    data1 = 0; data2 = 0; imm = 0; wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0;
    @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.ctrl", {23'd0, ctrlOut}, 32'd0);
    chk("rst.cnt", {16'd0, bubbleCnt}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) apply(vecs[i], $sformatf("v%0d", i));

    // twenty more load-use stalls: narrow counter must pin at 15
    exp_cnt = 3;
    for (int k = 0; k < 20; k++) begin
      sv = '{1,0,0, 1,8,0, LW, 1,2,3, 0,0,0, 0,1,LW, 1,8,0, 1,2,3, exp_cnt};
      apply(sv, $sformatf("sat%0d.lw", k));
      exp_cnt++;
      sv = '{1,0,0, 8,3,4, ADD, 5,6,7, 0,0,0, 1,0,0, 0,0,0, 0,0,0, exp_cnt};
      apply(sv, $sformatf("sat%0d.stall", k));
      sv = '{1,0,0, 8,3,4, ADD, 5,6,7, 0,0,0, 0,1,ADD, 8,3,4, 5,6,7, exp_cnt};
      apply(sv, $sformatf("sat%0d.add", k));
    end

    // asynchronous reset while a stall is pending
    sv = '{1,0,0, 1,8,0, LW, 1,2,3, 0,0,0, 0,1,LW, 1,8,0, 1,2,3, exp_cnt};
    apply(sv, "arst.lw");
    @(negedge clk);
    rs = 8; rt = 3; rd = 4; ctrlIn = ADD; inValid = 1;
    #1;
    chk("arst.pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst.valid", {31'd0, valid}, 32'd0);
    chk("arst.ctrl", {23'd0, ctrlOut}, 32'd0);
    chk("arst.cnt", {16'd0, bubbleCnt}, 32'd0);
    chk("arst.cnt4", {28'd0, cnt_4}, 32'd0);
    chk("arst.d1", data1Out, 32'd0);
    chk("arst.rt", {27'd0, rtOut}, 32'd0);
    chk("arst.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.valid", {31'd0, valid}, 32'd1);
    chk("rel.ctrl", {23'd0, ctrlOut}, {23'd0, ADD});
    chk("rel.rs", {27'd0, rsOut}, 32'd8);
    chk("rel.cnt", {16'd0, bubbleCnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
